uart_frame_assembler: RTL

//  Upstream neighbour of logic_control: turns received UART bytes into a checked

---
 rtl/uart_frame_assembler.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler: assembles SOF/payload/XOR-checksum UART frames into a checked control_value/valid pair.
module uart_frame_assembler #(
  parameter int DATA_WIDTH = 8,
  parameter int INPUT_DATA_SIZE = 52,
  parameter int PAYLOAD_BYTES = 7,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      rx_data,
  input  logic                       rx_valid,
  input  logic [15:0]                timeout_cycles,
  input  logic                       control_ready,
  output logic [INPUT_DATA_SIZE-1:0] control_value,
  output logic                       control_valid,
  output logic                       frame_error,
  output logic [1:0]                 error_code,
  output logic [7:0]                 overrun_count,
  output logic                       busy
);
  localparam int SW = PAYLOAD_BYTES * DATA_WIDTH;
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, HOLD} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [INPUT_DATA_SIZE-1:0] value_q, value_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic [1:0] code_q, code_d;
  logic [7:0] ovr_q, ovr_d;
  logic is_sof, in_frame, expired, pad_bad, start;
  assign is_sof = rx_valid && rx_data == SOF_BYTE;
  assign in_frame = state_q == PAYLOAD || state_q == CHECK;
  assign expired = timeout_cycles != 16'd0 && timer_q >= timeout_cycles;
  assign pad_bad = |(shift_q >> INPUT_DATA_SIZE);
  // a handshake in HOLD frees the block, so a SOF in that same cycle starts a frame
  assign start = is_sof && (state_q == IDLE || (state_q == HOLD && control_ready));
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    csum_d = csum_q;
    cnt_d = cnt_q;
    timer_d = timer_q;
    value_d = value_q;
    valid_d = valid_q;
    ferr_d = 1'b0;
    code_d = code_q;
    ovr_d = ovr_q;
    if (start) begin
      state_d = PAYLOAD;
      shift_d = '0;
      csum_d = '0;
      cnt_d = '0;
      timer_d = '0;
    end
    if (in_frame && !rx_valid) begin
      if (expired) begin
        state_d = IDLE;
        ferr_d = 1'b1;
        code_d = 2'b10;
        timer_d = '0;
      end else timer_d = timer_q + 16'd1;
    end
    if (state_q == PAYLOAD && rx_valid) begin
      shift_d = {shift_q[SW-DATA_WIDTH-1:0], rx_data};
      csum_d = csum_q ^ rx_data;
      cnt_d = cnt_q + 1'b1;
      timer_d = '0;
      state_d = cnt_q == CW'(PAYLOAD_BYTES - 1) ? CHECK : PAYLOAD;
    end
    if (state_q == CHECK && rx_valid) begin
      timer_d = '0;
      state_d = (rx_data != csum_q || pad_bad) ? IDLE : HOLD;
      ferr_d = rx_data != csum_q || pad_bad;
      code_d = rx_data != csum_q ? 2'b01 : pad_bad ? 2'b11 : code_q;
      valid_d = rx_data == csum_q && !pad_bad;
      value_d = (rx_data == csum_q && !pad_bad) ? shift_q[INPUT_DATA_SIZE-1:0] : value_q;
    end
    if (state_q == HOLD) begin
      valid_d = !control_ready;
      state_d = control_ready ? (is_sof ? PAYLOAD : IDLE) : HOLD;
      ovr_d = (rx_valid && !control_ready) ? ovr_q + 8'(ovr_q != 8'hFF) : ovr_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      csum_q <= '0;
      cnt_q <= '0;
      timer_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      code_q <= 2'b00;
      ovr_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      csum_q <= csum_d;
      cnt_q <= cnt_d;
      timer_q <= timer_d;
      value_q <= value_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      code_q <= code_d;
      ovr_q <= ovr_d;
    end
  end
  assign control_value = value_q;
  assign control_valid = valid_q;
  assign frame_error = ferr_q;
  assign error_code = code_q;
  assign overrun_count = ovr_q;
  assign busy = state_q != IDLE;
endmodule
